// File: rtl/lfsr_am_pkg.sv
// ============================================================================
// Module      : lfsr_am_pkg
// Description : Shared types and helpers for the LFSR-ordered associative
//               memory search and write-side sequencers.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package lfsr_am_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } search_state_t;

    // Maximal-length Fibonacci feedback masks for left-shifting LFSRs.
    function automatic logic [7:0] default_taps(input int width);
        case (width)
            3:       return 8'b0000_0110;
            4:       return 8'b0000_1100;
            5:       return 8'b0001_0100;
            6:       return 8'b0011_0000;
            7:       return 8'b0110_0000;
            8:       return 8'b1011_1000;
            default: return 8'b0000_1100;
        endcase
    endfunction

    function automatic int n_ent(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_step.sv
// ============================================================================
// Module      : lfsr_step
// Description : Combinational next-state of a Fibonacci LFSR (shift left,
//               feedback into bit 0).
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lfsr_step #(
    parameter int                ADDR_W = 4,
    parameter logic [ADDR_W-1:0] TAPS   = 4'b1100
) (
    input  logic [ADDR_W-1:0] i_lfsr,
    output logic [ADDR_W-1:0] o_lfsr_next
);

    logic w_fb;

    assign w_fb        = ^(i_lfsr & TAPS);
    assign o_lfsr_next = {i_lfsr[ADDR_W-2:0], w_fb};

endmodule

`default_nettype wire

// File: rtl/lfsr_search_ctrl.sv
// ============================================================================
// Module      : lfsr_search_ctrl
// Description : Walks the associative memory in LFSR order, feeds the
//               comparator and reports the first matching address.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lfsr_search_ctrl
    import lfsr_am_pkg::*;
#(
    parameter int                ADDR_W = 4,
    parameter int                DATA_W = 8,
    parameter logic [ADDR_W-1:0] TAPS   = ADDR_W'(default_taps(ADDR_W)),
    parameter logic [ADDR_W-1:0] SEED   = ADDR_W'(1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] Key,
    output logic              Busy,
    output logic              Done,
    output logic              Found,
    output logic [ADDR_W-1:0] Found_Addr,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Rd_En,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic [DATA_W-1:0] Cmp_Temp,
    output logic [DATA_W-1:0] Cmp_Mem_Data,
    output logic              Cmp_Enable,
    input  logic              Compare_Found
);

    localparam logic [ADDR_W-1:0] c_last_issue = ADDR_W'(n_ent(ADDR_W) - 1);

    search_state_t     r_state;
    search_state_t     w_state_next;
    logic [ADDR_W-1:0] r_lfsr;
    logic [ADDR_W-1:0] w_lfsr_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_key;
    logic              r_valid;
    logic              r_found;
    logic [ADDR_W-1:0] r_found_addr;
    logic              w_hit;
    logic              w_issue;
    logic              w_accept;

    lfsr_step #(
        .ADDR_W (ADDR_W),
        .TAPS   (TAPS)
    ) u_lfsr_step (
        .i_lfsr      (r_lfsr),
        .o_lfsr_next (w_lfsr_next)
    );

    // A hit suppresses the read that would otherwise issue in the same cycle,
    // so nothing is left in flight once the result is known.
    assign w_hit    = r_valid & Compare_Found;
    assign w_issue  = (r_state == ST_SCAN) & ~w_hit;
    assign w_accept = (r_state == ST_IDLE) & Start;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Start) w_state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_hit)                       w_state_next = ST_FINISH;
                else if (r_count == c_last_issue) w_state_next = ST_DRAIN;
            end
            ST_DRAIN:  w_state_next = ST_FINISH;
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_lfsr       <= SEED;
            r_addr       <= '0;
            r_count      <= '0;
            r_key        <= '0;
            r_valid      <= 1'b0;
            r_found      <= 1'b0;
            r_found_addr <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_issue;
            if (w_accept) begin
                r_key        <= Key;
                r_lfsr       <= SEED;
                r_count      <= '0;
                r_found      <= 1'b0;
                r_found_addr <= '0;
            end
            if (w_issue) begin
                r_addr  <= r_lfsr;
                r_lfsr  <= w_lfsr_next;
                r_count <= r_count + 1'b1;
            end
            if (w_hit) begin
                r_found      <= 1'b1;
                r_found_addr <= r_addr;
            end
        end
    end

    assign Busy         = (r_state != ST_IDLE);
    assign Done         = (r_state == ST_FINISH);
    assign Found        = r_found;
    assign Found_Addr   = r_found_addr;
    assign Mem_Rd_En    = w_issue;
    assign Mem_Addr     = w_issue ? r_lfsr : '0;
    assign Cmp_Temp     = r_key;
    assign Cmp_Mem_Data = Mem_Data;
    assign Cmp_Enable   = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_search_ctrl.sv
// ============================================================================
// Module      : tb_lfsr_search_ctrl
// Description : Directed bench for lfsr_search_ctrl with a 1-cycle memory
//               model and an equality comparator.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lfsr_search_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] Key = 8'h00;
    logic       Busy, Done, Found, Mem_Rd_En, Cmp_Enable, Compare_Found;
    logic [3:0] Found_Addr, Mem_Addr;
    logic [7:0] Mem_Data, Cmp_Temp, Cmp_Mem_Data;
    logic [7:0] mem [16];

    int n_vec = 0;
    int n_err = 0;
    int n_enable = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        Mem_Data <= mem[Mem_Addr];
        if (Cmp_Enable) n_enable <= n_enable + 1;
    end

    // Comparator output is deliberately not gated by its enable.
    assign Compare_Found = (Cmp_Temp == Cmp_Mem_Data);

    lfsr_search_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .Key           (Key),
        .Busy          (Busy),
        .Done          (Done),
        .Found         (Found),
        .Found_Addr    (Found_Addr),
        .Mem_Addr      (Mem_Addr),
        .Mem_Rd_En     (Mem_Rd_En),
        .Mem_Data      (Mem_Data),
        .Cmp_Temp      (Cmp_Temp),
        .Cmp_Mem_Data  (Cmp_Mem_Data),
        .Cmp_Enable    (Cmp_Enable),
        .Compare_Found (Compare_Found)
    );

    typedef struct {
        logic [7:0] key;
        int         a0;
        int         a1;
        int         exp_found;
        int         exp_addr;
        int         exp_done;
        int         exp_reads;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [7:0] key, input int a0, input int a1);
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        mem[0] = 8'hFF;
        if (a0 != 0) mem[a0] = key;
        if (a1 != 0) mem[a1] = key;
    endtask

    // Called just after a rising edge; that cycle is cycle 0 (Start accepted).
    task automatic run_search(input logic [7:0] key, input int ign1, input int ign2,
                              input int ign3, output int done_cyc, output int reads,
                              output int bad_addr, output int busy_bad,
                              output int post_busy, output int post_done);
        done_cyc = -1;
        reads    = 0;
        bad_addr = 0;
        busy_bad = 0;
        Start    = 1'b1;
        Key      = key;
        for (int c = 1; c <= 40; c++) begin
            @(posedge Clk);
            #1;
            if (Mem_Rd_En) begin
                reads++;
                if (Mem_Addr == 4'd0) bad_addr++;
            end
            if (!Busy) busy_bad++;
            Key   = 8'h00;
            Start = (c == ign1 || c == ign2 || c == ign3);
            if (Done) begin
                done_cyc = c;
                break;
            end
        end
        @(posedge Clk);
        #1;
        Start     = 1'b0;
        post_busy = int'(Busy);
        post_done = int'(Done);
    endtask

    initial begin
        int dc, rd, ba, bb, pb, pd, en0, seen_done;

        vecs[0] = '{8'hA5,  1,  0, 1,  1,  3,  1};
        vecs[1] = '{8'h3C,  8,  0, 1,  8, 17, 15};
        vecs[2] = '{8'hFF,  0,  0, 0,  0, 17, 15};
        vecs[3] = '{8'h5A, 13,  4, 1,  4,  5,  3};
        vecs[4] = '{8'h77, 15,  0, 1, 15, 14, 12};
        vecs[5] = '{8'h42, 12,  0, 1, 12, 16, 14};

        load_mem(8'h00, 0, 0);
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy",       int'(Busy),       0);
        check("rst_done",       int'(Done),       0);
        check("rst_found",      int'(Found),      0);
        check("rst_found_addr", int'(Found_Addr), 0);
        check("rst_rd_en",      int'(Mem_Rd_En),  0);
        check("rst_mem_addr",   int'(Mem_Addr),   0);
        check("rst_cmp_en",     int'(Cmp_Enable), 0);
        check("rst_cmp_temp",   int'(Cmp_Temp),   0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            load_mem(vecs[v].key, vecs[v].a0, vecs[v].a1);
            en0 = n_enable;
            run_search(vecs[v].key, -1, -1, -1, dc, rd, ba, bb, pb, pd);
            check($sformatf("v%0d_done_cycle", v), dc, vecs[v].exp_done);
            check($sformatf("v%0d_found", v),      int'(Found), vecs[v].exp_found);
            check($sformatf("v%0d_found_addr", v), int'(Found_Addr), vecs[v].exp_addr);
            check($sformatf("v%0d_reads", v),      rd, vecs[v].exp_reads);
            check($sformatf("v%0d_compares", v),   n_enable - en0, vecs[v].exp_reads);
            check($sformatf("v%0d_addr0_reads", v), ba, 0);
            check($sformatf("v%0d_busy_gaps", v),  bb, 0);
            check($sformatf("v%0d_post_busy", v),  pb, 0);
            check($sformatf("v%0d_post_done", v),  pd, 0);
            // Idle with Mem_Addr=0: comparator may fire on mem[0] with enable low.
            repeat (4) @(posedge Clk);
            #1;
            check($sformatf("v%0d_hold_found", v), int'(Found), vecs[v].exp_found);
            check($sformatf("v%0d_hold_addr", v),  int'(Found_Addr), vecs[v].exp_addr);
        end

        // Start pulses with Key=00 mid-search and during the Done cycle are ignored.
        load_mem(8'h3C, 8, 0);
        run_search(8'h3C, 2, 5, 17, dc, rd, ba, bb, pb, pd);
        check("ign_done_cycle", dc, 17);
        check("ign_found",      int'(Found), 1);
        check("ign_found_addr", int'(Found_Addr), 8);
        check("ign_key_kept",   int'(Cmp_Temp), 8'h3C);
        check("ign_reads",      rd, 15);
        check("ign_finish_start", pb, 0);
        repeat (6) @(posedge Clk);
        #1;
        check("ign_hold_found", int'(Found), 1);
        check("ign_hold_addr",  int'(Found_Addr), 8);

        // Reset in cycle 6 of a scan aborts with no Done.
        Start = 1'b1;
        Key   = 8'h3C;
        seen_done = 0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge Clk);
            #1;
            Start = 1'b0;
            if (Done) seen_done++;
            if (c == 6) Reset = 1'b1;
            if (c == 7) begin
                check("rst_mid_busy",  int'(Busy),      0);
                check("rst_mid_rd_en", int'(Mem_Rd_En), 0);
                check("rst_mid_found", int'(Found),     0);
                Reset = 1'b0;
            end
        end
        repeat (3) begin
            @(posedge Clk);
            #1;
            if (Done) seen_done++;
        end
        check("rst_mid_no_done", seen_done, 0);

        load_mem(8'hA5, 1, 0);
        run_search(8'hA5, -1, -1, -1, dc, rd, ba, bb, pb, pd);
        check("after_rst_done_cycle", dc, 3);
        check("after_rst_found",      int'(Found), 1);
        check("after_rst_found_addr", int'(Found_Addr), 1);
        check("after_rst_reads",      rd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
